// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    // Encoding of the RV32I EBREAK instruction; transferring it halts fetch.
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    // Sequential fetch advances one 32-bit word at a time.
    localparam logic [31:0] PC_STEP = 32'h0000_0004;

    // One prefetch buffer slot: the fetch address and the word read there.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '{pc: 32'h0000_0000, inst: 32'h0000_0000};

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Redirect targets are forced to a word boundary; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, inst} entries between fetch and decode.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic          wr_en_s;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == CNT_ZERO);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointer/occupancy values.
    always_comb begin
        push_ok_s = push & (~full | pop);
        pop_ok_s  = pop & ~empty;
        wr_en_s   = push_ok_s & ~flush;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush) begin
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ENTRY_ZERO;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch sequencer: owns the fetch PC, reads the async ROM,
// buffers {pc, inst} pairs for decode, follows redirects and stops on EBREAK.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [31:0]                 rom_addr,
    input  logic [31:0]                 rom_data,
    input  logic                        fetch_en,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    output logic                        inst_valid,
    output logic [31:0]                 inst,
    output logic [31:0]                 inst_pc,
    input  logic                        inst_ready,
    output logic                        halted,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    logic         pop_s;
    logic         push_s;
    logic         ebreak_s;
    logic         flush_s;
    logic         fifo_full_s;
    logic         fifo_empty_s;
    fetch_entry_t head_s;
    fetch_entry_t wr_entry_s;

    assign rom_addr   = pc_q;
    assign inst_valid = ~fifo_empty_s & (state_q == RUN);
    assign inst       = head_s.inst;
    assign inst_pc    = head_s.pc;
    assign halted     = (state_q == HALT);
    assign wr_entry_s = '{pc: pc_q, inst: rom_data};

    // Handshake decode: redirect beats EBREAK, and both suppress a new push.
    always_comb begin
        pop_s    = inst_valid & inst_ready;
        ebreak_s = pop_s & (head_s.inst == EBREAK_INST) & ~redirect_valid;
        push_s   = (state_q == RUN) & fetch_en & ~redirect_valid & ~ebreak_s
                   & (~fifo_full_s | pop_s);
        flush_s  = redirect_valid | ebreak_s;
    end

    // Next fetch PC and front-end state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    pc_d    = align_pc(redirect_pc);
                    state_d = RUN;
                end else if (ebreak_s) begin
                    pc_d    = pc_q;
                    state_d = HALT;
                end else if (push_s) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = RUN;
                end else begin
                    pc_d    = pc_q;
                    state_d = RUN;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    pc_d    = align_pc(redirect_pc);
                    state_d = RUN;
                end else begin
                    pc_d    = pc_q;
                    state_d = HALT;
                end
            end
            default: begin
                pc_d    = pc_q;
                state_d = RUN;
            end
        endcase
    end

    // Fetch PC and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .pop      (pop_s),
        .flush    (flush_s),
        .wr_entry (wr_entry_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count),
        .head     (head_s)
    );

endmodule
